// File: rtl/mips_defs_pkg.sv
// Definitions shared by the fetch stage and the decoder: opcodes, funct codes,
// ALU op encodings, the Jmp code and the jump-target helper.
package mips_defs;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_SLT = 4'd4,
    ALU_SLL = 4'd5
  } alu_op_t;

  localparam logic [1:0] JMP_NONE = 2'b00;
  localparam logic [1:0] JMP_J    = 2'b01;
  localparam logic [1:0] JMP_JR   = 2'b10;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  // j/jal target: upper nibble of the delay-free PC+4, word index from the instruction.
  function automatic logic [31:0] j_target(input logic [31:0] pc4, input logic [31:0] instr);
    return {pc4[31:28], instr[25:0], 2'b00};
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: flush injects a bubble, load captures a fetch, otherwise hold.
module ifid_reg
  import mips_defs::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_flush,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc4,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc4,
  output logic        o_valid
);

  logic [31:0] r_instr;
  logic [31:0] r_pc4;
  logic        r_valid;

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_instr <= NOP_INSTR;
      r_pc4   <= 32'd0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_instr <= i_instr;
      r_pc4   <= i_pc4;
      r_valid <= 1'b1;
    end
  end

  assign o_instr = r_instr;
  assign o_pc4   = r_pc4;
  assign o_valid = r_valid;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC, next-PC selection (branch > stall > jump > sequential),
// fetch/bubble counters and the IF/ID register.
module if_stage
  import mips_defs::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        ex_branch_taken,
  input  logic [31:0] ex_branch_target,
  input  logic [1:0]  id_jmp,
  input  logic [31:0] id_jr_target,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic [5:0]  opcode,
  output logic [5:0]  func,
  output logic        id_flush,
  output logic [31:0] fetch_count,
  output logic [31:0] bubble_count
);

  logic [31:0] r_pc;
  logic [31:0] r_fetch_count;
  logic [31:0] r_bubble_count;

  logic [31:0] w_pc4;
  logic        w_jmp_take;
  logic [31:0] w_jmp_target;
  logic        w_ifid_load;
  logic        w_ifid_flush;
  logic [31:0] w_ifid_instr;
  logic [31:0] w_ifid_pc4;
  logic        w_ifid_valid;

  assign w_pc4 = r_pc + 32'd4;

  // A bubble in IF/ID must never redirect, whatever the decoder drives.
  assign w_jmp_take   = w_ifid_valid && ((id_jmp == JMP_J) || (id_jmp == JMP_JR));
  assign w_jmp_target = (id_jmp == JMP_JR) ? id_jr_target : j_target(w_ifid_pc4, w_ifid_instr);

  assign w_ifid_flush = ex_branch_taken || (!stall && w_jmp_take);
  assign w_ifid_load  = !ex_branch_taken && !stall && !w_jmp_take;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc           <= RESET_PC;
      r_fetch_count  <= 32'd0;
      r_bubble_count <= 32'd0;
    end else if (ex_branch_taken) begin
      r_pc           <= ex_branch_target;
      r_bubble_count <= r_bubble_count + 32'd1;
    end else if (stall) begin
      r_pc <= r_pc;
    end else if (w_jmp_take) begin
      r_pc           <= w_jmp_target;
      r_bubble_count <= r_bubble_count + 32'd1;
    end else begin
      r_pc          <= w_pc4;
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  ifid_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_ifid_reg (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_ifid_load),
    .i_flush (w_ifid_flush),
    .i_instr (imem_rdata),
    .i_pc4   (w_pc4),
    .o_instr (w_ifid_instr),
    .o_pc4   (w_ifid_pc4),
    .o_valid (w_ifid_valid)
  );

  assign imem_addr    = r_pc;
  assign ifid_instr   = w_ifid_instr;
  assign ifid_pc4     = w_ifid_pc4;
  assign ifid_valid   = w_ifid_valid;
  assign opcode       = w_ifid_instr[31:26];
  assign func         = w_ifid_instr[5:0];
  assign id_flush     = ex_branch_taken;
  assign fetch_count  = r_fetch_count;
  assign bubble_count = r_bubble_count;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: sequential fetch, stall, j, jr under stall,
// branch priority, reset priority and PC wrap.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        ex_branch_taken;
  logic [31:0] ex_branch_target;
  logic [1:0]  id_jmp;
  logic [31:0] id_jr_target;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic [5:0]  opcode;
  logic [5:0]  func;
  logic        id_flush;
  logic [31:0] fetch_count;
  logic [31:0] bubble_count;

  int n_cmp = 0;
  int n_bad = 0;

  if_stage dut (
    .clk              (clk),
    .rst              (rst),
    .imem_addr        (imem_addr),
    .imem_rdata       (imem_rdata),
    .stall            (stall),
    .ex_branch_taken  (ex_branch_taken),
    .ex_branch_target (ex_branch_target),
    .id_jmp           (id_jmp),
    .id_jr_target     (id_jr_target),
    .ifid_instr       (ifid_instr),
    .ifid_pc4         (ifid_pc4),
    .ifid_valid       (ifid_valid),
    .opcode           (opcode),
    .func             (func),
    .id_flush         (id_flush),
    .fetch_count      (fetch_count),
    .bubble_count     (bubble_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory image; unlisted addresses return addi-like words tagged with the address.
  always_comb begin
    case (imem_addr)
      32'h0000_0000: imem_rdata = 32'h2008_0005;
      32'h0000_0004: imem_rdata = 32'h2009_0003;
      32'h0000_0008: imem_rdata = 32'h200A_0001;
      32'h0000_000C: imem_rdata = 32'h0800_0040;
      32'h0000_0100: imem_rdata = 32'h200B_0007;
      32'h0000_0104: imem_rdata = 32'h03E0_0008;
      default:       imem_rdata = {16'h2010, imem_addr[15:0]};
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                           input logic [31:0] pc4, input logic valid,
                           input logic [31:0] fc, input logic [31:0] bc);
    chk({tag, ".pc"},     imem_addr, pc);
    chk({tag, ".instr"},  ifid_instr, instr);
    chk({tag, ".pc4"},    ifid_pc4, pc4);
    chk({tag, ".valid"},  {31'd0, ifid_valid}, {31'd0, valid});
    chk({tag, ".fetch"},  fetch_count, fc);
    chk({tag, ".bubble"}, bubble_count, bc);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; ex_branch_taken = 1'b0; ex_branch_target = 32'd0;
    id_jmp = 2'b00; id_jr_target = 32'd0;
    step();
    chk_state("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0, 32'd0);
    chk("reset.flush", {31'd0, id_flush}, 32'd0);

    // Sequential fetch
    rst = 1'b0;
    step();
    chk_state("seq1", 32'h4, 32'h2008_0005, 32'h4, 1'b1, 32'd1, 32'd0);
    chk("seq1.opcode", {26'd0, opcode}, 32'h08);
    chk("seq1.func", {26'd0, func}, 32'h05);
    step();
    chk_state("seq2", 32'h8, 32'h2009_0003, 32'h8, 1'b1, 32'd2, 32'd0);

    // Stall two cycles at PC=8
    stall = 1'b1;
    step();
    chk_state("stall1", 32'h8, 32'h2009_0003, 32'h8, 1'b1, 32'd2, 32'd0);
    step();
    chk_state("stall2", 32'h8, 32'h2009_0003, 32'h8, 1'b1, 32'd2, 32'd0);
    stall = 1'b0;
    step();
    chk_state("resume", 32'hC, 32'h200A_0001, 32'hC, 1'b1, 32'd3, 32'd0);
    step();
    chk_state("fetch_j", 32'h10, 32'h0800_0040, 32'h10, 1'b1, 32'd4, 32'd0);
    chk("fetch_j.opcode", {26'd0, opcode}, 32'h02);

    // j 0x40 -> 0x100, one bubble
    id_jmp = 2'b01;
    step();
    chk_state("j", 32'h100, 32'h0, 32'h0, 1'b0, 32'd4, 32'd1);
    // id_jmp still asserted, but IF/ID holds a bubble: must not redirect
    step();
    chk_state("j_bubble_ign", 32'h104, 32'h200B_0007, 32'h104, 1'b1, 32'd5, 32'd1);
    id_jmp = 2'b00;
    step();
    chk_state("fetch_jr", 32'h108, 32'h03E0_0008, 32'h108, 1'b1, 32'd6, 32'd1);

    // jr under a one-cycle stall
    id_jmp = 2'b10; id_jr_target = 32'h0000_0200; stall = 1'b1;
    step();
    chk_state("jr_stall", 32'h108, 32'h03E0_0008, 32'h108, 1'b1, 32'd6, 32'd1);
    stall = 1'b0;
    step();
    chk_state("jr", 32'h200, 32'h0, 32'h0, 1'b0, 32'd6, 32'd2);
    id_jmp = 2'b00;
    step();
    chk_state("after_jr", 32'h204, 32'h2010_0200, 32'h204, 1'b1, 32'd7, 32'd2);

    // id_jmp=11 behaves as none
    id_jmp = 2'b11;
    step();
    chk_state("jmp11", 32'h208, 32'h2010_0204, 32'h208, 1'b1, 32'd8, 32'd2);

    // Branch beats stall and jump on the same edge
    ex_branch_taken = 1'b1; ex_branch_target = 32'h0000_0040; stall = 1'b1; id_jmp = 2'b01;
    #1;
    chk("br.flush_comb", {31'd0, id_flush}, 32'd1);
    step();
    chk_state("branch", 32'h40, 32'h0, 32'h0, 1'b0, 32'd8, 32'd3);

    // Reset wins over a taken branch
    ex_branch_target = 32'h0000_0080; stall = 1'b0; id_jmp = 2'b00; rst = 1'b1;
    step();
    chk_state("rst_br", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0, 32'd0);

    // Branch to the top word, then sequential fetch wraps PC+4 to 0
    rst = 1'b0; ex_branch_target = 32'hFFFF_FFFC;
    step();
    chk_state("br_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 32'd0, 32'd1);
    ex_branch_taken = 1'b0;
    #1;
    chk("top.flush_comb", {31'd0, id_flush}, 32'd0);
    step();
    chk_state("wrap", 32'h0, 32'h2010_FFFC, 32'h0, 1'b1, 32'd1, 32'd1);

    // Reset mid-stream from a plain sequential state
    rst = 1'b1;
    step();
    chk_state("rst_seq", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register for the 5-stage MIPS core.
- Holds the PC, drives instruction memory, and registers the fetched word.
- Presents opcode/func to the decoder (cntrl) downstream.
- Consumes the decoder's Jmp code, the EX-stage branch resolution and the hazard unit's stall, and selects the next PC and bubble insertion from them.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, word injected into IF/ID on flush (sll $0,$0,0)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
imem_addr  output  32  current PC to instruction memory (combinational read)
imem_rdata  input  32  instruction at imem_addr, valid same cycle
stall  input  1  load-use hazard: hold PC and IF/ID
ex_branch_taken  input  1  branch in EX resolved taken (beq/bne)
ex_branch_target  input  32  target for ex_branch_taken
id_jmp  input  2  decoder Jmp code for the IF/ID instruction: 00 none, 01 j/jal, 10 jr/jalr, 11 treated as 00
id_jr_target  input  32  forwarded rs value for jr/jalr
ifid_instr  output  32  registered instruction
ifid_pc4  output  32  registered PC+4 of that instruction
ifid_valid  output  1  1 = real fetched instruction, 0 = bubble
opcode  output  6  ifid_instr[31:26]
func  output  6  ifid_instr[5:0]
id_flush  output  1  combinational; 1 when ex_branch_taken (downstream bubbles ID/EX)
fetch_count  output  32  instructions loaded into IF/ID with valid=1
bubble_count  output  32  NOP_INSTR insertions

Behaviour:
- Reset (rst=1 at edge):
  - PC=RESET_PC; ifid_instr=NOP_INSTR; ifid_pc4=0; ifid_valid=0.
  - Both counters=0.
  - rst has priority over all other inputs, including mid-redirect.
- imem_addr = PC, always combinational; pc4 = PC+32'd4, mod 2^32 (0xFFFF_FFFC wraps to 0).
- j target = {ifid_pc4[31:28], ifid_instr[25:0], 2'b00}; jr target = id_jr_target. No byte-alignment check.
- Per-edge priority, highest first:
  1. ex_branch_taken: PC<=ex_branch_target; IF/ID<=NOP_INSTR, valid 0, pc4 0; bubble_count+1. Overrides stall and any id_jmp, because the ID instruction is wrong-path.
  2. stall: PC and IF/ID hold; no counter change. A pending id_jmp waits and takes effect on the first non-stalled edge.
  3. id_jmp=01 or 10 (ifid_valid=1 only): PC<=target; IF/ID<=NOP_INSTR, valid 0; bubble_count+1. No delay slot; the word fetched this cycle is discarded.
  4. Otherwise: PC<=pc4; ifid_instr<=imem_rdata; ifid_pc4<=pc4; valid 1; fetch_count+1.
- id_jmp is ignored when ifid_valid=0, so a bubble never redirects.
- id_flush = ex_branch_taken, with no gating by stall.
- Counters wrap at 2^32.
- Latency: a fetched instruction appears on ifid_instr/opcode/func one edge after its PC is on imem_addr.
- Taken-branch or jump penalty is one bubble at IF/ID.

Decomposition:
- Shared package/header `mips_defs`:
  - opcode/funct macros and ALU op codes (shared with cntrl);
  - JMP_NONE/JMP_J/JMP_JR = 2'b00/01/10;
  - NOP_INSTR default.
- One sub-module, `ifid_reg`: the IF/ID register with load/flush/hold controls and ifid_valid.
- PC, next-PC mux and counters stay in if_stage.

Test Plan:
1. Reset then 3 free-running cycles with imem returning 0x2008_0005 at 0, 0x2009_0003 at 4 → imem_addr 0,4,8,12; ifid_instr 0x2008_0005 then 0x2009_0003; opcode 6'b001000; fetch_count=3.
2. stall=1 for 2 cycles at PC=8 → imem_addr stays 8, ifid_instr unchanged, counters unchanged; resumes at 12.
3. IF/ID holds j 0x0000040 (0x0800_0040) with ifid_pc4=0x0000_0010 and id_jmp=01 → next PC=0x0000_0100, ifid_valid=0, bubble_count+1, following fetch from 0x100.
4. id_jmp=10, id_jr_target=0x0000_0200, with stall=1 for one cycle → PC holds one cycle, then becomes 0x200 with one bubble.
5. ex_branch_taken=1, target 0x0000_0040, with stall=1 and id_jmp=01 on the same edge → PC=0x40, id_flush=1, ifid_valid=0, bubble_count+1 (branch wins).
6. rst asserted in the cycle of a taken branch; PC=0xFFFF_FFFC with no redirect → PC=RESET_PC, all outputs at reset values; separately PC wraps to 0 and ifid_pc4=0.
